// File: rtl/io_input_capture.sv
// io_input_capture: synchronizes and debounces sw[9:0] and key[3:1], and latches
// key-press / switch-change events into sticky W1C registers on the MEM-stage bus.
// Ports:
//   ram_clock, resetn (async, active-low)
//   addr, datain, we  : shared MEM-stage bus
//   sw, key           : raw asynchronous pins
//   dataout, hit      : combinational read path
//   irq               : registered interrupt request
// Optional macro IO_CAPTURE_IRQ_EN adds the ien register at 0xffffffb0 and drives irq.
module io_input_capture #(
  parameter int DB_COUNT = 50000,
  parameter int DB_W     = 16
) (
  input  logic        ram_clock,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  input  logic [9:0]  sw,
  input  logic [3:1]  key,
  output logic [31:0] dataout,
  output logic        hit,
  output logic        irq
);

  localparam int N = 13;
  // Keys idle high, switches idle low.
  localparam logic [N-1:0] RST_V = {3'b111, 10'b0};
  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_COUNT - 1);

  logic [N-1:0]    raw;
  logic [N-1:0]    s1;
  logic [N-1:0]    s2;
  logic [N-1:0]    st;
  logic [N-1:0]    st_d;
  logic [DB_W-1:0] cnt [N];
  logic [3:1]      kev;
  logic            swev;

  logic a_sw;
  logic a_key;
  logic a_kev;
  logic a_swev;
  logic a_ien;

  logic [3:1] kev_set;
  logic [3:1] kev_clr;
  logic       swev_set;
  logic       swev_clr;

  assign raw = {key, sw};

  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      s1 <= RST_V;
      s2 <= RST_V;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      st <= RST_V;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          st[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign a_sw   = (addr == 32'hffff_ff00);
  assign a_key  = (addr == 32'hffff_ff10);
  assign a_kev  = (addr == 32'hffff_ff90);
  assign a_swev = (addr == 32'hffff_ffa0);

  // Events are detected one edge after st moves, using a delayed copy.
  assign kev_set  = st_d[12:10] & ~st[12:10];
  assign swev_set = |(st_d[9:0] ^ st[9:0]);
  assign kev_clr  = (we && a_kev) ? datain[3:1] : 3'b0;
  assign swev_clr = we && a_swev && datain[0];

  // Set is OR-ed after the clear so a colliding event survives.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      st_d <= RST_V;
      kev  <= '0;
      swev <= 1'b0;
    end else begin
      st_d <= st;
      kev  <= (kev & ~kev_clr) | kev_set;
      swev <= (swev & ~swev_clr) | swev_set;
    end
  end

`ifdef IO_CAPTURE_IRQ_EN
  logic [3:0] ien;
  logic       irq_q;

  assign a_ien = (addr == 32'hffff_ffb0);

  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      ien   <= '0;
      irq_q <= 1'b0;
    end else begin
      if (we && a_ien) begin
        ien <= datain[3:0];
      end
      irq_q <= |({kev, swev} & ien);
    end
  end

  assign irq = irq_q;

  logic unused;
  assign unused = ^datain[31:4];
`else
  assign a_ien = 1'b0;
  assign irq   = 1'b0;

  logic unused;
  assign unused = ^datain[31:4];
`endif

  assign hit = a_sw | a_key | a_kev | a_swev | a_ien;

  always_comb begin
    dataout = '0;
    unique case (1'b1)
      a_sw:    dataout = {22'b0, st[9:0]};
      a_key:   dataout = {28'b0, st[12:10], 1'b1};
      a_kev:   dataout = {28'b0, kev, 1'b0};
      a_swev:  dataout = {31'b0, swev};
`ifdef IO_CAPTURE_IRQ_EN
      a_ien:   dataout = {28'b0, ien};
`endif
      default: dataout = '0;
    endcase
  end

endmodule

// File: tb/tb_io_input_capture.sv
// tb_io_input_capture: directed-vector bench for io_input_capture with DB_COUNT=4.
// Covers reset, debounce latency, glitch rejection, key events, W1C and irq.
module tb_io_input_capture;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [9:0]  sw;
  logic [3:1]  key;
  logic [31:0] dataout;
  logic        hit;
  logic        irq;

  int n_vec;
  int n_err;

  io_input_capture #(
    .DB_COUNT(4),
    .DB_W(16)
  ) dut (
    .ram_clock(clk),
    .resetn(rst_n),
    .addr(addr),
    .datain(datain),
    .we(we),
    .sw(sw),
    .key(key),
    .dataout(dataout),
    .hit(hit),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dataout, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    tick(1);
    we     = 1'b0;
    datain = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b1;
    addr   = '0;
    datain = '0;
    we     = 1'b0;
    sw     = '0;
    key    = 3'b111;

    // Reset with no clock edge.
    #1 rst_n = 1'b0;
    rd("rst_sw", 32'hffffff00, 32'h0);
    chk("rst_hit", {31'b0, hit}, 32'h1);
    rd("rst_key", 32'hffffff10, 32'hF);
    rd("rst_kev", 32'hffffff90, 32'h0);
    rd("rst_swev", 32'hffffffa0, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Switch debounce: 6 edges to st, 1 more to event.
    sw = 10'h155;
    tick(5);
    rd("sw_early", 32'hffffff00, 32'h0);
    tick(1);
    rd("sw_st", 32'hffffff00, 32'h155);
    rd("swev_early", 32'hffffffa0, 32'h0);
    tick(1);
    rd("swev_set", 32'hffffffa0, 32'h1);
    wr(32'hffffffa0, 32'h1);
    rd("swev_clr", 32'hffffffa0, 32'h0);

    // 3-cycle glitch on sw[0] must be rejected.
    sw = 10'h154;
    tick(3);
    sw = 10'h155;
    tick(8);
    rd("glitch_sw", 32'hffffff00, 32'h155);
    rd("glitch_ev", 32'hffffffa0, 32'h0);

    // Store to a read-only register is ignored.
    wr(32'hffffff00, 32'h0);
    rd("ro_sw", 32'hffffff00, 32'h155);

    // Key 2 press.
    key = 3'b101;
    tick(6);
    rd("key2_st", 32'hffffff10, 32'hB);
    tick(1);
    rd("key2_ev", 32'hffffff90, 32'h4);
    key = 3'b111;
    tick(8);
    rd("key2_rel", 32'hffffff10, 32'hF);
    rd("key2_stk", 32'hffffff90, 32'h4);
    chk("irq_idle", {31'b0, irq}, 32'h0);

    // W1C behaviour.
    wr(32'hffffff90, 32'h0);
    rd("w1c_zero", 32'hffffff90, 32'h4);
    wr(32'hffffff90, 32'h4);
    rd("w1c_clr", 32'hffffff90, 32'h0);

    // Key 3 event collides with a clearing store.
    key = 3'b011;
    tick(6);
    rd("key3_pre", 32'hffffff90, 32'h0);
    wr(32'hffffff90, 32'h8);
    rd("collide", 32'hffffff90, 32'h8);
    wr(32'hffffff90, 32'h8);
    rd("collide_clr", 32'hffffff90, 32'h0);
    key = 3'b111;
    tick(8);

`ifdef IO_CAPTURE_IRQ_EN
    wr(32'hffffffb0, 32'h2);
    rd("ien_rd", 32'hffffffb0, 32'h2);
    key = 3'b110;
    tick(7);
    rd("key1_ev", 32'hffffff90, 32'h2);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    tick(1);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    wr(32'hffffff90, 32'h2);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    tick(1);
    chk("irq_fall", {31'b0, irq}, 32'h0);
    key = 3'b111;
    tick(8);
`else
    addr = 32'hffffffb0;
    #1;
    chk("ien_hit", {31'b0, hit}, 32'h0);
    chk("ien_data", dataout, 32'h0);
    wr(32'hffffffb0, 32'hF);
    addr = 32'hffffffb0;
    #1;
    chk("ien_hit2", {31'b0, hit}, 32'h0);
    key = 3'b110;
    tick(8);
    rd("key1_ev", 32'hffffff90, 32'h2);
    chk("irq_off", {31'b0, irq}, 32'h0);
    wr(32'hffffff90, 32'h2);
    key = 3'b111;
    tick(8);
`endif

    // Mid-count reset during a key 1 press (cnt reaches 2).
    key = 3'b110;
    tick(4);
    rst_n = 1'b0;
    #1;
    rd("mid_key", 32'hffffff10, 32'hF);
    rd("mid_kev", 32'hffffff90, 32'h0);
    rd("mid_sw", 32'hffffff00, 32'h0);
    chk("mid_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    tick(5);
    rd("mid_hold5", 32'hffffff10, 32'hF);
    tick(1);
    rd("mid_hold6", 32'hffffff10, 32'hD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
